// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: constants and capture-FSM state encoding shared by the
// audio PWM player and the PWM capture receiver.
// Contents: PWM_PERIOD, PWM_SAMPLE_W, PWM_LOCK_CNT, cap_state_e.
// Optional feature macro used by the capture path: PWM_GLITCH_FILTER_EN.

package pwm_audio_pkg;

  // Clocks per PWM frame; the player's PWM counter wraps at this value.
  localparam int PWM_PERIOD   = 256;
  // Sample width carried over the PWM link.
  localparam int PWM_SAMPLE_W = 8;
  // Consecutive phase-0 rising edges needed before the receiver trusts its frame boundary.
  localparam int PWM_LOCK_CNT = 2;

  // Capture FSM states. Encoding is fixed so the values can be mirrored as
  // plain 2-bit constants in code that predates the enum.
  typedef enum logic [1:0] {
    CAP_HUNT   = 2'd0,
    CAP_ALIGN  = 2'd1,
    CAP_LOCKED = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: resynchronises the PWM line and flags its rising edges.
// Latency: 2 clocks to level/rise (3 with PWM_GLITCH_FILTER_EN); level and rise stay aligned.
// Backpressure: none; free-running, one level/rise decision every clock.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   din    in  asynchronous PWM line
//   level  out resynchronised (optionally filtered) line level
//   rise   out 1 in the first cycle that level is high after being low
// Configuration: define PWM_GLITCH_FILTER_EN to insert a 3-tap majority vote
// after the synchroniser, which swallows isolated 1-clock pulses of either polarity.

module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

`ifdef PWM_GLITCH_FILTER_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  // Majority of the current synchronised sample and the two before it. A run
  // of two or more passes through delayed by one clock; a lone sample cannot win.
  always_comb begin
    hist1_d = sync_q;
    hist2_d = hist1_q;
    level   = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end
`else
  always_comb begin
    level = sync_q;
  end
`endif

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = level;
    rise   = level & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/pwm_audio_capture.sv
// pwm_audio_capture: recovers one SAMPLE_W-bit sample per PWM frame from the audio player's PWM line.
// Latency: sample_valid 3 clocks after the frame's last pwm_in cycle (4 with PWM_GLITCH_FILTER_EN).
// Backpressure: none; sample_valid is a 1-clock pulse that must be taken when offered.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   pwm_in        in   asynchronous PWM line from the player
//   sample_out    out  high-clock count of the last frame, saturated to SAMPLE_W bits; held between pulses
//   sample_valid  out  1-clock pulse, sample_out valid in the same cycle
//   locked        out  frame alignment established
//   resync_err    out  1-clock pulse: rising edge away from phase 0 while locked
//   sample_count  out  samples emitted since reset, wraps at 2**32 (already includes a sample shown with valid)
// Configuration: PWM_GLITCH_FILTER_EN enables the majority filter in pwm_edge_sync.

module pwm_audio_capture #(
  parameter int PERIOD   = pwm_audio_pkg::PWM_PERIOD,
  parameter int SAMPLE_W = pwm_audio_pkg::PWM_SAMPLE_W,
  parameter int LOCK_CNT = pwm_audio_pkg::PWM_LOCK_CNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                locked,
  output logic                resync_err,
  output logic [31:0]         sample_count
);

  import pwm_audio_pkg::*;

  localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HC_W = $clog2(PERIOD + 1);
  localparam int GC_W = $clog2(LOCK_CNT + 1);

  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(PERIOD - 1);
  localparam logic [63:0]     MAX_SAMPLE = (64'd1 << SAMPLE_W) - 64'd1;

  localparam logic [1:0] ST_HUNT   = CAP_HUNT;
  localparam logic [1:0] ST_ALIGN  = CAP_ALIGN;
  localparam logic [1:0] ST_LOCKED = CAP_LOCKED;

  // A frame may hold PERIOD high clocks, which does not fit in SAMPLE_W bits
  // when PERIOD == 2**SAMPLE_W; clamp rather than wrap to zero.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [HC_W-1:0] h);
    if (64'(h) > MAX_SAMPLE) begin
      sat_sample = '1;
    end else begin
      sat_sample = SAMPLE_W'(h);
    end
  endfunction

  logic level;
  logic rise;

  pwm_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise)
  );

  logic [1:0]          state_q,  state_d;
  logic [PH_W-1:0]     phase_q,  phase_d;
  logic [HC_W-1:0]     hcnt_q,   hcnt_d;
  logic [GC_W-1:0]     good_q,   good_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q,  valid_d;
  logic                locked_q, locked_d;
  logic                resync_q, resync_d;
  logic [31:0]         count_q,  count_d;

  logic                frame_end;
  logic [HC_W-1:0]     hcnt_total;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    hcnt_d   = hcnt_q;
    good_d   = good_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    resync_d = 1'b0;
    count_d  = count_q;

    // hcnt_q holds the high clocks of phases 0..phase_q-1; hcnt_total adds the current cycle.
    frame_end  = (phase_q == PH_LAST);
    hcnt_total = hcnt_q + HC_W'(level);

    case (state_q)
      ST_HUNT: begin
        // The rising cycle itself is phase 0 of the first frame and counts as high.
        if (rise) begin
          state_d = ST_ALIGN;
          phase_d = PH_W'(1);
          hcnt_d  = HC_W'(1);
          good_d  = '0;
        end
      end

      ST_ALIGN, ST_LOCKED: begin
        phase_d = frame_end ? '0 : phase_q + PH_W'(1);
        hcnt_d  = frame_end ? '0 : hcnt_total;

        // Emission is decided by the state at the last phase, so the frame whose
        // opening edge completed the lock is already reported.
        if (frame_end && (state_q == ST_LOCKED)) begin
          sample_d = sat_sample(hcnt_total);
          valid_d  = 1'b1;
          count_d  = count_q + 32'd1;
        end

        if (rise && (phase_q != '0)) begin
          // Edge off the expected boundary: the running frame is not trustworthy.
          // A frame ending in this very cycle was already emitted above.
          resync_d = (state_q == ST_LOCKED);
          state_d  = ST_ALIGN;
          phase_d  = PH_W'(1);
          hcnt_d   = HC_W'(1);
          good_d   = '0;
        end else if (rise && (state_q == ST_ALIGN)) begin
          // Edge exactly on the boundary confirms the alignment once more.
          good_d = good_q + GC_W'(1);
          if (good_q == GC_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
          end
        end
        // Frames without any rise (all-low or all-high) keep the boundary from the phase counter.
      end

      default: begin
        state_d = ST_HUNT;
        phase_d = '0;
        hcnt_d  = '0;
        good_d  = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_HUNT;
      phase_q  <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      resync_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      resync_q <= resync_d;
      count_q  <= count_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign resync_err   = resync_q;
  assign sample_count = count_q;

endmodule
